// File: rtl/calc_sequencer.sv
// Calculator control FSM: operand entry, ALU start/done handshake with hang and range guards.
// Optional result chaining into operand A is enabled by defining CALC_CHAIN_EN.
module calc_sequencer #(
  parameter int WIDTH     = 14,
  parameter int MAX_VALUE = 9999,
  parameter int TIMEOUT   = 255
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             btn_clr,
  input  logic             btn_ent,
  input  logic [1:0]       op_sel,
  input  logic             alu_done,
  input  logic             alu_err,
  input  logic [WIDTH-1:0] alu_result,
  output logic             write_number_select,
  output logic             slider_clr,
  output logic             alu_start,
  output logic [1:0]       alu_op,
  output logic             alu_abort,
  output logic [1:0]       display_sel,
  output logic [WIDTH-1:0] result_q,
  output logic             error,
  output logic             busy,
  output logic             load_a,
  output logic [WIDTH-1:0] load_value
);

  typedef enum logic [2:0] {
    S_ENTER_A = 3'd0,
    S_ENTER_B = 3'd1,
    S_START   = 3'd2,
    S_WAIT    = 3'd3,
    S_SHOW    = 3'd4,
    S_ERROR   = 3'd5
  } state_t;

  localparam int                CW       = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0]     CNT_LAST = CW'(TIMEOUT - 1);
  localparam logic [CW-1:0]     CNT_ONE  = CW'(1);
  localparam logic [WIDTH-1:0]  MAX_V    = WIDTH'(MAX_VALUE);

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [1:0]       alu_op_q, alu_op_d;
  logic             slider_clr_q, slider_clr_d;
  logic             alu_start_q, alu_start_d;
  logic             alu_abort_q, alu_abort_d;
  logic [1:0]       disp_q, disp_d;
  logic             wns_q, wns_d;
  logic             busy_q, busy_d;
  logic             err_q, err_d;
  logic             done_ok_s;

  // An in-range, error-free result is the only way into SHOW
  assign done_ok_s = alu_done & ~alu_err & (alu_result <= MAX_V);

`ifdef CALC_CHAIN_EN
  logic load_a_q, load_a_d;
`endif

  // Next-state, datapath updates and registered-output decode
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    res_d        = res_q;
    alu_op_d     = alu_op_q;
    slider_clr_d = 1'b0;
    alu_start_d  = 1'b0;
    alu_abort_d  = 1'b0;
`ifdef CALC_CHAIN_EN
    load_a_d     = 1'b0;
`endif

    if (btn_clr) begin
      state_d      = S_ENTER_A;
      slider_clr_d = 1'b1;
      alu_op_d     = 2'd0;
      cnt_d        = '0;
      alu_abort_d  = (state_q == S_START) || (state_q == S_WAIT);
    end else begin
      case (state_q)
        S_ENTER_A: begin
          if (btn_ent) state_d = S_ENTER_B;
          else         state_d = S_ENTER_A;
        end
        S_ENTER_B: begin
          if (btn_ent) begin
            state_d     = S_START;
            alu_op_d    = op_sel;
            alu_start_d = 1'b1;
          end else begin
            state_d = S_ENTER_B;
          end
        end
        S_START: begin
          state_d = S_WAIT;
          cnt_d   = '0;
        end
        S_WAIT: begin
          // A done arriving in the timeout cycle takes priority over the abort
          if (alu_done) begin
            cnt_d = '0;
            if (done_ok_s) begin
              state_d = S_SHOW;
              res_d   = alu_result;
            end else begin
              state_d = S_ERROR;
            end
          end else if (cnt_q == CNT_LAST) begin
            state_d     = S_ERROR;
            alu_abort_d = 1'b1;
            cnt_d       = '0;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
        S_SHOW: begin
          if (btn_ent) begin
`ifdef CALC_CHAIN_EN
            load_a_d     = 1'b1;
            state_d      = S_ENTER_B;
`else
            slider_clr_d = 1'b1;
            state_d      = S_ENTER_A;
`endif
          end else begin
            state_d = S_SHOW;
          end
        end
        S_ERROR: begin
          if (btn_ent) begin
            state_d      = S_ENTER_A;
            slider_clr_d = 1'b1;
          end else begin
            state_d = S_ERROR;
          end
        end
        default: begin
          state_d = S_ENTER_A;
          cnt_d   = '0;
        end
      endcase
    end

    disp_d = 2'd0;
    wns_d  = 1'b0;
    busy_d = 1'b0;
    err_d  = 1'b0;
    // Status outputs follow the state being entered so they line up with state_q
    case (state_d)
      S_ENTER_A: disp_d = 2'd0;
      S_ENTER_B: begin
        disp_d = 2'd1;
        wns_d  = 1'b1;
      end
      S_START, S_WAIT: begin
        disp_d = 2'd1;
        wns_d  = 1'b1;
        busy_d = 1'b1;
      end
      S_SHOW:    disp_d = 2'd2;
      S_ERROR: begin
        disp_d = 2'd3;
        err_d  = 1'b1;
      end
      default:   disp_d = 2'd0;
    endcase
  end

  // State and output registers; reset returns to ENTER_A with everything cleared
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= S_ENTER_A;
      cnt_q        <= '0;
      res_q        <= '0;
      alu_op_q     <= 2'd0;
      slider_clr_q <= 1'b0;
      alu_start_q  <= 1'b0;
      alu_abort_q  <= 1'b0;
      disp_q       <= 2'd0;
      wns_q        <= 1'b0;
      busy_q       <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      res_q        <= res_d;
      alu_op_q     <= alu_op_d;
      slider_clr_q <= slider_clr_d;
      alu_start_q  <= alu_start_d;
      alu_abort_q  <= alu_abort_d;
      disp_q       <= disp_d;
      wns_q        <= wns_d;
      busy_q       <= busy_d;
      err_q        <= err_d;
    end
  end

`ifdef CALC_CHAIN_EN
  // Chain pulse register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) load_a_q <= 1'b0;
    else        load_a_q <= load_a_d;
  end

  assign load_a     = load_a_q;
  assign load_value = res_q;
`else
  assign load_a     = 1'b0;
  assign load_value = '0;
`endif

  assign write_number_select = wns_q;
  assign slider_clr          = slider_clr_q;
  assign alu_start           = alu_start_q;
  assign alu_op              = alu_op_q;
  assign alu_abort           = alu_abort_q;
  assign display_sel         = disp_q;
  assign result_q            = res_q;
  assign error               = err_q;
  assign busy                = busy_q;

endmodule

// File: tb/tb_calc_sequencer.sv
// Scoreboard bench for calc_sequencer: driver pushes expected events, monitor pops and compares.
module tb_calc_sequencer;
  localparam int W = 14;
  localparam int T = 8;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         btn_clr = 1'b0, btn_ent = 1'b0;
  logic [1:0]   op_sel = 2'd0;
  logic         alu_done = 1'b0, alu_err = 1'b0;
  logic [W-1:0] alu_result = '0;
  logic         write_number_select, slider_clr, alu_start, alu_abort, error, busy, load_a;
  logic [1:0]   alu_op, display_sel;
  logic [W-1:0] result_q, load_value;

  calc_sequencer #(.WIDTH(W), .MAX_VALUE(9999), .TIMEOUT(T)) dut (
    .clk(clk), .reset(reset), .btn_clr(btn_clr), .btn_ent(btn_ent), .op_sel(op_sel),
    .alu_done(alu_done), .alu_err(alu_err), .alu_result(alu_result),
    .write_number_select(write_number_select), .slider_clr(slider_clr),
    .alu_start(alu_start), .alu_op(alu_op), .alu_abort(alu_abort),
    .display_sel(display_sel), .result_q(result_q), .error(error), .busy(busy),
    .load_a(load_a), .load_value(load_value)
  );

  always #5 clk = ~clk;

  typedef enum int {EV_START, EV_ABORT, EV_SHOW, EV_ERR, EV_SCLR, EV_LOADA} ev_kind_t;
  typedef struct {ev_kind_t kind; int val; int busy;} ev_t;

  ev_t exp_q[$];
  int  n_checks = 0;
  int  n_pass = 0;
  int  model_res = 0;
  bit  at_b = 1'b0;

  task automatic check(input string name, input int act, input int expv);
    n_checks++;
    if (act == expv) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, expv);
  endtask

  task automatic push(input ev_kind_t k, input int v, input int b);
    ev_t e;
    e.kind = k; e.val = v; e.busy = b;
    exp_q.push_back(e);
  endtask

  task automatic observe(input ev_kind_t k, input int v, input int b);
    ev_t e;
    if (exp_q.size() == 0) begin
      check("unexpected event kind", int'(k), -1);
    end else begin
      e = exp_q.pop_front();
      check("event kind", int'(k), int'(e.kind));
      check("event value", v, e.val);
      check("event busy cycles", b, e.busy);
    end
  endtask

  // Monitor: turns DUT output activity into events and matches them against the queue
  initial begin
    int run = 0, last_run = 0;
    logic [1:0] prev_disp = 2'd0;
    logic prev_err = 1'b0;
    forever begin
      @(negedge clk);
      if (!reset) begin
        run = 0; prev_disp = 2'd0; prev_err = 1'b0;
      end else begin
        if (busy) run++;
        else if (run != 0) begin last_run = run; run = 0; end
        if (alu_start) observe(EV_START, int'(alu_op), 0);
        if (alu_abort) observe(EV_ABORT, 0, 0);
        if (display_sel == 2'd2 && prev_disp != 2'd2) observe(EV_SHOW, int'(result_q), last_run);
        if (error && !prev_err) observe(EV_ERR, int'(result_q), last_run);
        if (slider_clr) observe(EV_SCLR, 0, 0);
        if (load_a) observe(EV_LOADA, int'(load_value), 0);
        prev_disp = display_sel;
        prev_err = error;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse(input logic ent, input logic clr);
    btn_ent = ent; btn_clr = clr;
    tick();
    btn_ent = 1'b0; btn_clr = 1'b0;
  endtask

  // Leave SHOW/ERROR by ENT (ext=0) or CLR (ext=1)
  task automatic leave_result(input bit shown, input int ext);
    if (shown && ext == 0) begin
`ifdef CALC_CHAIN_EN
      push(EV_LOADA, model_res, 0);
      pulse(1'b1, 1'b0);
      at_b = 1'b1;
      check("chain enters B", int'(display_sel), 1);
`else
      push(EV_SCLR, 0, 0);
      pulse(1'b1, 1'b0);
      at_b = 1'b0;
      check("show ENT back to A", int'(display_sel), 0);
`endif
    end else begin
      push(EV_SCLR, 0, 0);
      pulse(ext == 0, ext == 1);
      at_b = 1'b0;
      check("exit to A", int'(display_sel), 0);
    end
  endtask

  // scen: 0 ALU answers in WAIT cycle j, 2 ALU hangs, 3 CLR in WAIT cycle j, 4 CLR+ENT in ENTER_B
  task automatic calc(input int scen, input int op, input int a, input int b, input int j, input int ext);
    int full;
    bit bad;
    bit shown;
    logic [W-1:0] drv;
    bad = 1'b0;
    case (op)
      0: full = a + b;
      1: begin full = a - b; bad = (b > a); end
      2: full = a * b;
      default: begin bad = (b == 0); full = (b == 0) ? 0 : a / b; end
    endcase
    if (!at_b) pulse(1'b1, 1'b0);
    check("wns in ENTER_B", int'(write_number_select), 1);
    check("display in ENTER_B", int'(display_sel), 1);
    op_sel = 2'(op);
    if (scen == 4) begin
      push(EV_SCLR, 0, 0);
      pulse(1'b1, 1'b1);
      at_b = 1'b0;
      check("clr+ent display", int'(display_sel), 0);
      check("clr+ent alu_op", int'(alu_op), 0);
      return;
    end
    push(EV_START, op, 0);
    pulse(1'b1, 1'b0);
    check("busy in START", int'(busy), 1);
    tick();
    check("alu_op held", int'(alu_op), op);
    if (scen == 2) begin
      push(EV_ABORT, 0, 0);
      push(EV_ERR, model_res, 1 + T);
      repeat (T) tick();
      check("timeout error", int'(error), 1);
      alu_done = 1'b1; alu_result = 14'd42;
      tick();
      alu_done = 1'b0;
      check("late done in ERROR", int'(display_sel), 3);
      leave_result(1'b0, ext);
    end else if (scen == 3) begin
      repeat (j - 1) tick();
      push(EV_ABORT, 0, 0);
      push(EV_SCLR, 0, 0);
      pulse(1'b0, 1'b1);
      check("clr wait display", int'(display_sel), 0);
      check("clr wait alu_op", int'(alu_op), 0);
      check("clr wait busy", int'(busy), 0);
      alu_done = 1'b1; alu_result = 14'd42;
      tick();
      alu_done = 1'b0;
      tick();
      check("late done ignored", int'(display_sel), 0);
      at_b = 1'b0;
    end else begin
      for (int i = 1; i < j; i++) begin
        btn_ent = 1'($urandom_range(0, 1));
        tick();
      end
      btn_ent = 1'b0;
      if (bad) drv = W'($urandom);
      else drv = (full > 16383) ? 14'd16383 : W'(full);
      shown = !bad && full <= 9999;
      if (shown) begin
        model_res = full;
        push(EV_SHOW, model_res, 1 + j);
      end else begin
        push(EV_ERR, model_res, 1 + j);
      end
      alu_done = 1'b1; alu_err = bad; alu_result = drv;
      tick();
      alu_done = 1'b0; alu_err = 1'b0;
      check("result display", int'(display_sel), shown ? 2 : 3);
      check("result_q", int'(result_q), model_res);
      leave_result(shown, ext);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int scen, k;
    repeat (3) @(posedge clk);
    #1;
    check("reset busy", int'(busy), 0);
    check("reset display", int'(display_sel), 0);
    check("reset result", int'(result_q), 0);
    check("reset alu_start", int'(alu_start), 0);
    check("reset error", int'(error), 0);
    reset = 1'b1;
    tick();
    check("idle wns", int'(write_number_select), 0);

    calc(0, 0, 12, 30, 5, 0);     // 12+30=42, done after 5 cycles
    calc(0, 3, 50, 0, 3, 0);      // divide by zero flagged by ALU
    calc(2, 1, 9, 3, 1, 1);       // ALU hangs
    calc(3, 2, 4, 5, 3, 0);       // CLR while waiting
    calc(4, 0, 1, 1, 1, 0);       // CLR+ENT in ENTER_B
    calc(0, 0, 9999, 1, 2, 1);    // 10000 out of range
    calc(0, 2, 7, 6, T, 0);       // done in the timeout cycle wins

    for (int n = 0; n < 40; n++) begin
      scen = $urandom_range(0, 4);
      if (scen == 1) scen = 0;
      k = $urandom_range(1, T);
      if (scen == 3 && k == T) k = T - 1;
      calc(scen, $urandom_range(0, 3), $urandom_range(0, 150), $urandom_range(0, 150),
           k, $urandom_range(0, 1));
    end

    // Reset in the middle of a WAIT
    if (model_res == 0) calc(0, 0, 3, 4, 2, 1);
    if (!at_b) pulse(1'b1, 1'b0);
    op_sel = 2'd2;
    push(EV_START, 2, 0);
    pulse(1'b1, 1'b0);
    tick(); tick();
    reset = 1'b0;
    #1;
    check("mid reset busy", int'(busy), 0);
    check("mid reset result", int'(result_q), 0);
    check("mid reset alu_op", int'(alu_op), 0);
    check("mid reset abort", int'(alu_abort), 0);
    tick();
    reset = 1'b1;
    model_res = 0; at_b = 1'b0;
    repeat (3) tick();
    check("idle after reset", int'(display_sel), 0);

    repeat (4) tick();
    check("scoreboard drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
